// File: rtl/dice_display.sv
// Dice result display: accepts a rolled value, plays a decelerating tumble
// animation on the 7-segment digit and pip LEDs, then holds the final face.
module dice_display #(
  parameter int unsigned FRAME_DIV   = 250000,
  parameter int unsigned SPIN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       val_valid,
  input  logic [3:0] val_data,
  output logic       val_ready,
  output logic [6:0] seg,
  output logic [6:0] pips,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(FRAME_DIV * SPIN_FRAMES + 1);
  localparam int unsigned FW = $clog2(SPIN_FRAMES + 1);

  typedef enum logic {SHOW, SPIN} state_e;

  state_e        state_q;
  logic [3:0]    value_q;
  logic          err_q;
  logic [6:0]    seg_q, pips_q;
  logic          ready_q, busy_q, done_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lim_q;
  logic [FW-1:0] frame_q;
  logic [2:0]    anim_q;
  logic [2:0]    anim_d;

  // Returns {seg, pips}; anything outside 1..6 maps to the dash/blank error look.
  function automatic logic [13:0] face_enc(input logic [3:0] f);
    case (f)
      4'd1:    face_enc = {7'b0110000, 7'b0001000};
      4'd2:    face_enc = {7'b1101101, 7'b1000001};
      4'd3:    face_enc = {7'b1111001, 7'b1001001};
      4'd4:    face_enc = {7'b0110011, 7'b1100011};
      4'd5:    face_enc = {7'b1011011, 7'b1101011};
      4'd6:    face_enc = {7'b1011111, 7'b1110111};
      default: face_enc = {7'b0000001, 7'b0000000};
    endcase
  endfunction

  always_comb begin
    anim_d = (anim_q == 3'd6) ? 3'd1 : anim_q + 3'd1;
  end

  // lim_q tracks FRAME_DIV*(frame+1)-1 incrementally, avoiding a multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= SHOW;
      value_q           <= 4'd1;
      err_q             <= 1'b0;
      {seg_q, pips_q}   <= face_enc(4'd1);
      ready_q           <= 1'b1;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      cnt_q             <= '0;
      lim_q             <= '0;
      frame_q           <= '0;
      anim_q            <= 3'd1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHOW: begin
          if (val_valid) begin
            value_q         <= val_data;
            err_q           <= (val_data == 4'd0) || (val_data > 4'd6);
            cnt_q           <= '0;
            lim_q           <= CW'(FRAME_DIV - 1);
            frame_q         <= '0;
            anim_q          <= 3'd1;
            {seg_q, pips_q} <= face_enc(4'd1);
            busy_q          <= 1'b1;
            ready_q         <= 1'b0;
            state_q         <= SPIN;
          end
        end
        SPIN: begin
          if (cnt_q == lim_q) begin
            cnt_q <= '0;
            if (frame_q == FW'(SPIN_FRAMES - 1)) begin
              {seg_q, pips_q} <= face_enc(err_q ? 4'd0 : value_q);
              busy_q          <= 1'b0;
              ready_q         <= 1'b1;
              done_q          <= 1'b1;
              state_q         <= SHOW;
            end else begin
              frame_q         <= frame_q + FW'(1);
              lim_q           <= lim_q + CW'(FRAME_DIV);
              anim_q          <= anim_d;
              {seg_q, pips_q} <= face_enc({1'b0, anim_d});
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= SHOW;
      endcase
    end
  end

  assign val_ready = ready_q;
  assign seg       = seg_q;
  assign pips      = pips_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dice_display.sv
// Bench for dice_display: table-driven rolls with a result scoreboard, plus
// hand-written backpressure, reset-in-spin and face wrap-around sequences.
module tb_dice_display;

  logic       clk;
  logic       reset;
  logic       val_valid;
  logic [3:0] val_data;
  logic       val_ready;
  logic [6:0] seg, pips;
  logic       busy, done, err;

  logic       b_valid;
  logic [3:0] b_data;
  logic       b_ready;
  logic [6:0] b_seg, b_pips;
  logic       b_busy, b_done, b_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] d;
    logic [6:0] seg;
    logic [6:0] pips;
    logic       err;
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic [6:0] pips;
    logic       err;
  } exp_t;

  exp_t sb[$];
  vec_t tab[6];

  dice_display #(.FRAME_DIV(2), .SPIN_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .val_valid(val_valid), .val_data(val_data),
    .val_ready(val_ready), .seg(seg), .pips(pips), .busy(busy), .done(done), .err(err)
  );

  dice_display #(.FRAME_DIV(1), .SPIN_FRAMES(8)) dut_wrap (
    .clk(clk), .reset(reset), .val_valid(b_valid), .val_data(b_data),
    .val_ready(b_ready), .seg(b_seg), .pips(b_pips), .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [6:0] face_seg(input int f);
    case (f)
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] face_pips(input int f);
    case (f)
      1: return 7'b0001000;
      2: return 7'b1000001;
      3: return 7'b1001001;
      4: return 7'b1100011;
      5: return 7'b1101011;
      6: return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Face expected n cycles into a spin: frame k lasts fd*(k+1) cycles.
  function automatic int exp_face(input int n, input int fd);
    int acc = 0;
    for (int k = 0; k < 64; k++) begin
      acc += fd * (k + 1);
      if (n < acc) return (k % 6) + 1;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Called at a negedge; transfer happens on the following posedge.
  task automatic xfer(input logic [3:0] d, input logic [6:0] s, input logic [6:0] p, input logic e);
    exp_t x;
    check("ready_before_xfer", val_ready, 1);
    val_valid = 1'b1;
    val_data  = d;
    x.seg = s; x.pips = p; x.err = e;
    sb.push_back(x);
    @(negedge clk);
    val_valid = 1'b0;
    check("busy_after_xfer", busy, 1);
    check("ready_after_xfer", val_ready, 0);
    check("seg_first_face", seg, face_seg(1));
    check("err_latched", err, e);
  endtask

  // Entered at the first spin cycle's negedge; returns at the done negedge.
  task automatic wait_done();
    int   n = 0;
    int   bad = -1;
    exp_t x;
    while (busy === 1'b1 && n < 200) begin
      if (bad < 0 && (seg !== face_seg(exp_face(n, 2)) || pips !== face_pips(exp_face(n, 2))))
        bad = n;
      n++;
      @(negedge clk);
    end
    check("spin_len", n, 12);
    check("timeline_first_bad_cycle", bad, -1);
    check("done_pulse", done, 1);
    check("ready_after_spin", val_ready, 1);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      x = sb.pop_front();
      check("final_seg", seg, x.seg);
      check("final_pips", pips, x.pips);
      check("final_err", err, x.err);
    end
  endtask

  initial begin
    int n;
    int bad;
    reset = 1'b1;
    val_valid = 1'b0; val_data = 4'd0;
    b_valid = 1'b0;   b_data = 4'd0;

    // Reset values, seen before any clock edge
    #3;
    check("rst_seg", seg, 7'b0110000);
    check("rst_pips", pips, 7'b0001000);
    check("rst_ready", val_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    tab[0] = '{4'd5, 7'b1011011, 7'b1101011, 1'b0};
    tab[1] = '{4'd0, 7'b0000001, 7'b0000000, 1'b1};
    tab[2] = '{4'd9, 7'b0000001, 7'b0000000, 1'b1};
    tab[3] = '{4'd6, 7'b1011111, 7'b1110111, 1'b0};
    tab[4] = '{4'd1, 7'b0110000, 7'b0001000, 1'b0};
    tab[5] = '{4'd3, 7'b1111001, 7'b1001001, 1'b0};

    for (int i = 0; i < 6; i++) begin
      xfer(tab[i].d, tab[i].seg, tab[i].pips, tab[i].err);
      wait_done();
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("face_held", seg, tab[i].seg);
      check("idle_busy", busy, 0);
    end

    // Backpressure: valid held with 4 through the spin, second roll back-to-back
    done_cnt = 0;
    xfer(4'd5, 7'b1011011, 7'b1101011, 1'b0);
    val_valid = 1'b1;
    val_data  = 4'd4;
    begin
      exp_t x;
      x.seg = 7'b0110011; x.pips = 7'b1100011; x.err = 1'b0;
      sb.push_back(x);
    end
    wait_done();
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_ready", val_ready, 0);
    check("b2b_done_low", done, 0);
    val_valid = 1'b0;
    wait_done();
    @(negedge clk);
    #1;
    check("b2b_done_count", done_cnt, 2);

    // Reset in the middle of a spin
    done_cnt = 0;
    xfer(4'd3, 7'b1111001, 7'b1001001, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_seg", seg, 7'b0110000);
    check("midrst_pips", pips, 7'b0001000);
    check("midrst_busy", busy, 0);
    check("midrst_ready", val_ready, 1);
    check("midrst_done", done, 0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    xfer(4'd2, 7'b1101101, 7'b1000001, 1'b0);
    wait_done();
    @(negedge clk);
    #1;
    check("post_rst_done_count", done_cnt, 1);

    // Wrap-around instance: faces 1..6,1,2 over 36 cycles, then the latched 2
    b_valid = 1'b1;
    b_data  = 4'd2;
    @(negedge clk);
    b_valid = 1'b0;
    n = 0;
    bad = -1;
    while (b_busy === 1'b1 && n < 200) begin
      if (bad < 0 && b_seg !== face_seg(exp_face(n, 1))) bad = n;
      n++;
      @(negedge clk);
    end
    check("wrap_spin_len", n, 36);
    check("wrap_first_bad_cycle", bad, -1);
    check("wrap_done", b_done, 1);
    check("wrap_final_seg", b_seg, 7'b1101101);
    check("wrap_final_pips", b_pips, 7'b1000001);
    @(negedge clk);
    check("wrap_done_low", b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
